// File: rtl/vga_arb_pkg.sv
// Shared types for the VGA write-port arbiter: FSM states, grant sources and
// the buffered CPU write entry.
package vga_arb_pkg;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = ID_W + DATA_W;

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    GAP
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_KB
  } gnt_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage; the head entry is always presented on rd_data.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/vga_port_arbiter.sv
// Shares the VGA register-write port between buffered CPU writes and keyboard
// req/ack writes, issuing one-cycle strobes separated by a guaranteed low gap.
module vga_port_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          CPU_WS,
  input  logic [7:0]                    CPU_ID,
  input  logic [7:0]                    CPU_DATA,
  input  logic                          KB_REQ,
  input  logic [7:0]                    KB_ID,
  input  logic [7:0]                    KB_DATA,
  output logic                          KB_ACK,
  output logic                          WRITE_STROBE,
  output logic [7:0]                    POR_ID,
  output logic [7:0]                    OUT_PORT,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW,
  input  logic                          CLR_OVF
);

  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

  state_t          state_q, state_d;
  gnt_t            last_q, last_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            strobe_q, strobe_d;
  logic            ack_q, ack_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      data_q, data_d;
  logic            ovf_q, ovf_d;

  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            cpu_pending;
  wr_entry_t       push_entry;
  wr_entry_t       head;

  assign push_entry = '{id: CPU_ID, data: CPU_DATA};
  assign cpu_pending = !fifo_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_cpu_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (CPU_WS),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head),
    .count   (FIFO_COUNT),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ARB;
      last_q   <= GNT_KB;
      gap_q    <= '0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
      id_q     <= id_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, grant and output-register logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gap_d    = gap_q;
    strobe_d = 1'b0;
    ack_d    = 1'b0;
    id_d     = id_q;
    data_d   = data_q;
    pop      = 1'b0;

    unique case (state_q)
      ARB: begin
        // CPU wins when alone, or on a tie when the keyboard was served last.
        if (cpu_pending && (!KB_REQ || last_q == GNT_KB)) begin
          pop      = 1'b1;
          id_d     = head.id;
          data_d   = head.data;
          last_d   = GNT_CPU;
          strobe_d = 1'b1;
          state_d  = ISSUE;
        end else if (KB_REQ) begin
          id_d     = KB_ID;
          data_d   = KB_DATA;
          last_d   = GNT_KB;
          strobe_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = GW'(GAP_CYCLES - 1);
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = ARB;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ARB;
    endcase

    // A dropped write sets the flag even when a clear arrives on the same edge.
    if (CPU_WS && fifo_full && !pop) ovf_d = 1'b1;
    else if (CLR_OVF)                ovf_d = 1'b0;
    else                             ovf_d = ovf_q;
  end

  assign WRITE_STROBE = strobe_q;
  assign KB_ACK       = ack_q;
  assign POR_ID       = id_q;
  assign OUT_PORT     = data_q;
  assign OVERFLOW     = ovf_q;

endmodule

// File: doc/vga_port_arbiter.md
# vga_port_arbiter

Shares the VGA register-write port (WRITE_STROBE / POR_ID / OUT_PORT) between the microcontroller output port and the keyboard echo path, so both can update the VGA register file without colliding. CPU writes cannot be stalled and are buffered in a small FIFO. Keyboard writes use a req/ack handshake. Issued strobes are paced with a guaranteed low gap, because the VGA top updates its registers on the strobe's rising edge. The block sits between the control core / keyboard translator and the VGA top inside the control–VGA–keyboard interconnect.

## Interface
Parameters:
- FIFO_DEPTH, 4: CPU write buffer entries; power of two, ≥2.
- GAP_CYCLES, 2: minimum WRITE_STROBE-low cycles after each strobe; ≥1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CPU_WS  in  1  CPU write strobe; one-cycle pulse per write.
- CPU_ID  in  8  CPU port ID; valid with CPU_WS.
- CPU_DATA  in  8  CPU data; valid with CPU_WS.
- KB_REQ  in  1  keyboard write request; held until KB_ACK.
- KB_ID  in  8  keyboard target port ID; stable while KB_REQ is high.
- KB_DATA  in  8  keyboard data; stable while KB_REQ is high.
- KB_ACK  out  1  one-cycle pulse, coincident with the strobe carrying keyboard data.
- WRITE_STROBE  out  1  write strobe to the VGA top.
- POR_ID  out  8  port ID to the VGA top.
- OUT_PORT  out  8  data to the VGA top.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  current CPU FIFO occupancy.
- OVERFLOW  out  1  sticky flag: a CPU write was dropped.
- CLR_OVF  in  1  clears OVERFLOW.

## Operation
- CPU side:
  - CPU_WS pushes {CPU_ID, CPU_DATA} into the FIFO.
  - A push is accepted if FIFO_COUNT < FIFO_DEPTH, or if a pop happens on the same edge.
  - Otherwise the write is dropped and OVERFLOW is set.
  - If OVERFLOW is set and CLR_OVF is asserted on the same edge, set wins.
- Keyboard side: a request is pending while KB_REQ=1. KB_ACK completes it. If KB_REQ is still high on the cycle after KB_ACK, that is a new request.
- Arbitration:
  - Happens in ARB only.
  - Only one requester pending: that one is granted.
  - Both pending: round-robin via a last_grant bit.
  - last_grant resets to KB, so the CPU wins the first tie.
- FSM:
  - ARB: if any requester is pending, load POR_ID/OUT_PORT from the winner, assert WRITE_STROBE, go to ISSUE. If the CPU wins, pop the FIFO. If KB wins, assert KB_ACK.
  - ISSUE: single cycle; WRITE_STROBE and KB_ACK drop; go to GAP with gap counter = GAP_CYCLES-1.
  - GAP: counter reaching 0 → ARB; otherwise decrement.
- POR_ID/OUT_PORT hold their last issued value until the next issue; they never glitch during GAP.
- Simultaneous push and pop: FIFO_COUNT is unchanged.
- Pushes at FIFO_COUNT=0 are allowed in any state.
- Reset (including mid-operation):
  - FIFO flushed, FIFO_COUNT=0, OVERFLOW=0, state ARB.
  - WRITE_STROBE=0, KB_ACK=0, POR_ID=0, OUT_PORT=0, last_grant=KB.
  - A KB_REQ that is still high after reset is re-arbitrated normally.

## Timing
- All outputs are registered.
- CPU latency: CPU_WS high in cycle n with the FIFO empty and the FSM in ARB → pushed at edge n. Arbitration in n+1, WRITE_STROBE high in n+2.
- KB latency: KB_REQ first seen high in cycle n with the FSM in ARB → WRITE_STROBE and KB_ACK high in n+1.
- Strobe width: exactly 1 cycle.
- Strobe period under continuous backlog: 2+GAP_CYCLES cycles (ISSUE + GAP + ARB); 4 cycles at defaults.
- Minimum strobe-low time: GAP_CYCLES+1 cycles.
- Throughput: the FIFO drains no faster than one entry per 2+GAP_CYCLES cycles. A CPU burst faster than that overflows after FIFO_DEPTH entries plus drained slots.

## Structure
- Package vga_arb_pkg holds:
  - the state enum {ARB, ISSUE, GAP};
  - the grant-source enum {GNT_CPU, GNT_KB};
  - the 16-bit write-entry typedef {id[7:0], data[7:0]}.
- One sub-module, sync_fifo: parameterised depth/width, push/pop/count/full/empty, synchronous active-high reset, registered read data at the head. It holds the CPU entries.

## Test plan
- Reset, then a single CPU_WS with ID=0x21, DATA=0x45 at cycle 10 → WRITE_STROBE at cycle 12 with POR_ID=0x21, OUT_PORT=0x45. KB_ACK stays 0; FIFO_COUNT returns to 0.
- KB_REQ held with ID=0x30, DATA=0x1C → exactly one KB_ACK, coincident with the strobe carrying 0x30/0x1C. A REQ kept high is re-served 4 cycles later.
- CPU burst of 3 writes while KB_REQ is also pending from reset → strobe order CPU1, KB, CPU2, KB, CPU3, 4 cycles apart.
- 8 back-to-back CPU_WS, no KB activity → the first 6 are issued in order, OVERFLOW=1, FIFO_COUNT peaks at 4. CLR_OVF clears OVERFLOW; CLR_OVF together with a new drop leaves it at 1.
- RST asserted in the cycle after a strobe, with 3 FIFO entries pending → next edge: all outputs 0, FIFO_COUNT=0, no stale entry issued afterwards.
- GAP_CYCLES=1 build with continuous backlog → strobes every 3 cycles, never two adjacent high cycles.
